// File: rtl/sqrt_block_engine.sv
// sqrt_block_engine: walks a RAM window and writes floor(sqrt(x)) plus remainder per word
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   St              start request, accepted in IDLE only
//   BaseAddr, Len   job window: first address and word count (0..2**AW)
//   RdAddr, RdData  source RAM port, data valid one cycle after address
//   WrEn, WrAddr    result RAM write strobe and address
//   WrRoot, WrRem   floor(sqrt(x)) and x - root^2
//   Busy, Done      job in progress / one-cycle completion pulse
module sqrt_block_engine #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            St,
    input  logic [AW-1:0]   BaseAddr,
    input  logic [AW:0]     Len,
    output logic [AW-1:0]   RdAddr,
    input  logic [DW-1:0]   RdData,
    output logic            WrEn,
    output logic [AW-1:0]   WrAddr,
    output logic [DW/2-1:0] WrRoot,
    output logic [DW/2:0]   WrRem,
    output logic            Busy,
    output logic            Done
);
    localparam int HW = DW / 2;
    localparam int RW = HW + 1;
    localparam int IW = $clog2(HW + 1);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, CALC, WRITE, DONE} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, rd_hold_q, rd_hold_d, wr_addr_q, wr_addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] x_q, x_d;
    logic [RW-1:0] rem_q, rem_d, rem_nx, wr_rem_q, wr_rem_d;
    logic [HW-1:0] root_q, root_d, root_nx, wr_root_q, wr_root_d;
    logic [IW-1:0] it_q, it_d;
    logic [HW+2:0] rem_sh, trial;
    logic          ge;
    // rem never exceeds 2*root, so HW+1 bits hold it; the wider shifted
    // value is only needed transiently for the compare/subtract.
    always_comb begin
        rem_sh  = {rem_q, x_q[DW-1 -: 2]};
        trial   = {1'b0, root_q, 2'b01};
        ge      = rem_sh >= trial;
        rem_nx  = ge ? RW'(rem_sh - trial) : RW'(rem_sh);
        root_nx = (root_q << 1) | HW'(ge);
    end
    // An empty job still spends its FETCH cycle (Busy high) but issues no read.
    assign RdAddr = (state_q == FETCH && cnt_q != '0) ? addr_q : rd_hold_q;
    assign WrEn   = state_q == WRITE;
    assign WrAddr = wr_addr_q;
    assign WrRoot = wr_root_q;
    assign WrRem  = wr_rem_q;
    assign Busy   = state_q != IDLE && state_q != DONE;
    assign Done   = state_q == DONE;
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        rem_d     = rem_q;
        root_d    = root_q;
        it_d      = it_q;
        rd_hold_d = rd_hold_q;
        wr_addr_d = wr_addr_q;
        wr_root_d = wr_root_q;
        wr_rem_d  = wr_rem_q;
        case (state_q)
            IDLE: if (St) begin
                addr_d  = BaseAddr;
                cnt_d   = Len;
                state_d = FETCH;
            end
            FETCH: begin
                rd_hold_d = RdAddr;
                state_d   = cnt_q == '0 ? DONE : LOAD;
            end
            LOAD: begin
                x_d     = RdData;
                rem_d   = '0;
                root_d  = '0;
                it_d    = '0;
                state_d = CALC;
            end
            CALC: begin
                rem_d  = rem_nx;
                root_d = root_nx;
                x_d    = x_q << 2;
                it_d   = it_q + 1'b1;
                if (it_q == IW'(HW - 1)) begin
                    wr_addr_d = addr_q;
                    wr_root_d = root_nx;
                    wr_rem_d  = rem_nx;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == 1 ? DONE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            it_q      <= '0;
            rd_hold_q <= '0;
            wr_addr_q <= '0;
            wr_root_q <= '0;
            wr_rem_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            it_q      <= it_d;
            rd_hold_q <= rd_hold_d;
            wr_addr_q <= wr_addr_d;
            wr_root_q <= wr_root_d;
            wr_rem_q  <= wr_rem_d;
        end
    end
endmodule

// File: tb/tb_sqrt_block_engine.sv
// tb_sqrt_block_engine: directed checks of the block sqrt engine in two configurations
module tb_sqrt_block_engine;
    logic CLK = 0, RST = 0;
    always #5 CLK = ~CLK;
    int checks = 0, failures = 0, cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic       st_a = 0, wren_a, busy_a, done_a;
    logic [3:0] base_a = 0, rdaddr_a, wraddr_a, wrroot_a;
    logic [4:0] len_a = 0, wrrem_a;
    logic [7:0] rddata_a = 0;
    logic [7:0] mem_a [16];

    logic        st_b = 0, wren_b, busy_b, done_b;
    logic [2:0]  base_b = 0, rdaddr_b, wraddr_b;
    logic [3:0]  len_b = 0;
    logic [15:0] rddata_b = 0;
    logic [7:0]  wrroot_b;
    logic [8:0]  wrrem_b;
    logic [15:0] mem_b [8];

    sqrt_block_engine #(.DW(8), .AW(4)) dut_a (
        .CLK(CLK), .RST(RST), .St(st_a), .BaseAddr(base_a), .Len(len_a),
        .RdAddr(rdaddr_a), .RdData(rddata_a), .WrEn(wren_a), .WrAddr(wraddr_a),
        .WrRoot(wrroot_a), .WrRem(wrrem_a), .Busy(busy_a), .Done(done_a));
    sqrt_block_engine #(.DW(16), .AW(3)) dut_b (
        .CLK(CLK), .RST(RST), .St(st_b), .BaseAddr(base_b), .Len(len_b),
        .RdAddr(rdaddr_b), .RdData(rddata_b), .WrEn(wren_b), .WrAddr(wraddr_b),
        .WrRoot(wrroot_b), .WrRem(wrrem_b), .Busy(busy_b), .Done(done_b));

    always @(posedge CLK) begin
        rddata_a <= mem_a[rdaddr_a];
        rddata_b <= mem_b[rdaddr_b];
    end

    int qa_addr[$], qa_root[$], qa_rem[$], qb_addr[$], qb_root[$], qb_rem[$];
    int ndone_a = 0, ndone_b = 0, nbusy_a = 0, tdone_a = 0, tdone_b = 0;
    always @(negedge CLK) begin
        if (wren_a) begin
            qa_addr.push_back(int'(wraddr_a));
            qa_root.push_back(int'(wrroot_a));
            qa_rem.push_back(int'(wrrem_a));
        end
        if (wren_b) begin
            qb_addr.push_back(int'(wraddr_b));
            qb_root.push_back(int'(wrroot_b));
            qb_rem.push_back(int'(wrrem_b));
        end
        if (busy_a) nbusy_a++;
        if (done_a) begin ndone_a++; tdone_a = cyc; end
        if (done_b) begin ndone_b++; tdone_b = cyc; end
    end

    task automatic clear_a();
        qa_addr.delete(); qa_root.delete(); qa_rem.delete();
        ndone_a = 0; nbusy_a = 0;
    endtask

    // Latency is counted from the edge sampling St to the edge sampling Done.
    task automatic run_a(input logic [3:0] b, input logic [4:0] l, output int lat);
        int t0;
        clear_a();
        @(negedge CLK); st_a = 1; base_a = b; len_a = l;
        @(posedge CLK); #1 t0 = cyc;
        @(negedge CLK); st_a = 0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK); #1;
            if (ndone_a > 0) begin lat = tdone_a - t0 + 1; break; end
        end
    endtask

    task automatic run_b(input logic [2:0] b, input logic [3:0] l, output int lat);
        int t0;
        qb_addr.delete(); qb_root.delete(); qb_rem.delete(); ndone_b = 0;
        @(negedge CLK); st_b = 1; base_b = b; len_b = l;
        @(posedge CLK); #1 t0 = cyc;
        @(negedge CLK); st_b = 0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK); #1;
            if (ndone_b > 0) begin lat = tdone_b - t0 + 1; break; end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if ({wren_a, busy_a, done_a, rdaddr_a, wraddr_a, wrroot_a, wrrem_a} !== 16'd0 ||
            {wren_b, busy_b, done_b, rdaddr_b, wraddr_b, wrroot_b, wrrem_b} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: got a=%h b=%h expected 0",
                {wren_a, busy_a, done_a, rdaddr_a, wraddr_a, wrroot_a, wrrem_a},
                {wren_b, busy_b, done_b, rdaddr_b, wraddr_b, wrroot_b, wrrem_b});
        end
        @(negedge CLK); RST = 1;
    endtask

    task automatic test_basic();
        int lat;
        int er[5] = '{0, 1, 3, 4, 15};
        int em[5] = '{0, 0, 6, 0, 30};
        mem_a[0] = 0; mem_a[1] = 1; mem_a[2] = 15; mem_a[3] = 16; mem_a[4] = 255;
        run_a(4'd0, 5'd5, lat);
        chk("basic_latency", lat, 36);
        chk("basic_busy_cycles", nbusy_a, 35);
        chk("basic_writes", qa_addr.size(), 5);
        for (int i = 0; i < 5 && i < qa_addr.size(); i++) begin
            chk("basic_addr", qa_addr[i], i);
            chk("basic_root", qa_root[i], er[i]);
            chk("basic_rem", qa_rem[i], em[i]);
        end
        chk("basic_busy_after", int'(busy_a), 0);
    endtask

    task automatic test_empty();
        int lat;
        run_a(4'd3, 5'd0, lat);
        chk("empty_latency", lat, 2);
        chk("empty_busy_cycles", nbusy_a, 1);
        chk("empty_writes", qa_addr.size(), 0);
    endtask

    task automatic test_wrap();
        int lat;
        int ea[4] = '{14, 15, 0, 1};
        int er[4] = '{10, 14, 0, 1};
        int em[4] = '{0, 4, 0, 0};
        mem_a[14] = 100; mem_a[15] = 200; mem_a[0] = 0; mem_a[1] = 1;
        run_a(4'd14, 5'd4, lat);
        chk("wrap_writes", qa_addr.size(), 4);
        for (int i = 0; i < 4 && i < qa_addr.size(); i++) begin
            chk("wrap_addr", qa_addr[i], ea[i]);
            chk("wrap_root", qa_root[i], er[i]);
            chk("wrap_rem", qa_rem[i], em[i]);
        end
    endtask

    task automatic test_full();
        int lat, a, r, m, x;
        for (int i = 0; i < 16; i++) mem_a[i] = 8'(i * 17);
        run_a(4'd5, 5'd16, lat);
        chk("full_latency", lat, 113);
        chk("full_writes", qa_addr.size(), 16);
        for (int i = 0; i < 16 && i < qa_addr.size(); i++) begin
            a = qa_addr[i]; r = qa_root[i]; m = qa_rem[i];
            x = ((5 + i) % 16) * 17;
            chk("full_addr", a, (5 + i) % 16);
            chk("full_root_rem", ((r * r + m == x) && (m <= 2 * r)) ? 1 : 0, 1);
        end
    endtask

    task automatic test_back_to_back();
        clear_a();
        @(negedge CLK); st_a = 1; base_a = 4'd2; len_a = 5'd2;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK); #1;
            if (ndone_a > 0) break;
        end
        @(negedge CLK); st_a = 0;
        repeat (40) @(negedge CLK);
        #1;
        chk("b2b_writes", qa_addr.size(), 2);
        chk("b2b_done_pulses", ndone_a, 1);
        chk("b2b_busy_after", int'(busy_a), 0);
    endtask

    task automatic test_reset_mid();
        int lat;
        mem_a[2] = 15; mem_a[3] = 16; mem_a[4] = 255;
        clear_a();
        @(negedge CLK); st_a = 1; base_a = 4'd2; len_a = 5'd5;
        @(negedge CLK); st_a = 0;
        repeat (10) @(negedge CLK);
        chk("mid_first_root", int'(wrroot_a), 3);
        RST = 0;
        #1;
        chk("mid_reset_outputs",
            int'({wren_a, busy_a, done_a, rdaddr_a, wraddr_a, wrroot_a, wrrem_a}), 0);
        repeat (3) @(negedge CLK);
        RST = 1;
        clear_a();
        repeat (60) @(negedge CLK);
        chk("mid_no_writes", qa_addr.size(), 0);
        chk("mid_no_done", ndone_a, 0);
        run_a(4'd4, 5'd1, lat);
        chk("mid_restart_latency", lat, 8);
        chk("mid_restart_root", qa_root.size() > 0 ? qa_root[0] : -1, 15);
        chk("mid_restart_rem", qa_rem.size() > 0 ? qa_rem[0] : -1, 30);
    endtask

    task automatic test_wide();
        int lat;
        mem_b[0] = 16'd65535; mem_b[1] = 16'd40000;
        run_b(3'd0, 4'd2, lat);
        chk("wide_latency", lat, 23);
        chk("wide_writes", qb_addr.size(), 2);
        if (qb_addr.size() == 2) begin
            chk("wide_root0", qb_root[0], 255);
            chk("wide_rem0", qb_rem[0], 510);
            chk("wide_root1", qb_root[1], 200);
            chk("wide_rem1", qb_rem[1], 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_a[i] = 0;
        for (int i = 0; i < 8; i++) mem_b[i] = 0;
        test_reset();
        test_basic();
        test_empty();
        test_wrap();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
